// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: req/gnt address phase plus rvalid data phase.
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC and the IF/ID register, fetches one word at a time over
// req/gnt + rvalid, parks a returned word while stalled and kills fetches on redirect.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              if_id_write,
  input  logic              if_id_flush,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  fetch_stage_if.master     imem,
  output logic [XLEN-1:0]   if_id_pc,
  output logic [XLEN-1:0]   if_id_pc4,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic              fetch_misaligned
);

  typedef enum logic [1:0] {S_REQ, S_WAIT_RSP, S_HOLD} state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            kill_q, kill_d;
  logic [31:0]     hold_q, hold_d;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc4_q, id_pc4_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic            id_valid_q, id_valid_d;

  logic            adv;
  logic            deliver;
  logic [31:0]     deliver_word;

  assign adv            = pc_write & if_id_write & ~if_id_flush;
  assign imem.imem_req  = (state_q == S_REQ) & ~redirect_valid;
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    kill_d       = kill_q;
    hold_d       = hold_q;
    misaligned_d = 1'b0;
    deliver      = 1'b0;
    deliver_word = hold_q;

    if (redirect_valid) begin
      // Redirect wins over stalls; any outstanding response becomes garbage.
      pc_d         = {redirect_pc[XLEN-1:2], 2'b00};
      misaligned_d = |redirect_pc[1:0];
      case (state_q)
        S_WAIT_RSP: begin
          if (imem.imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end
        S_HOLD: begin
          hold_d  = '0;
          state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem.imem_gnt) begin
            fetch_pc_d = pc_q;
            state_d    = S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (imem.imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else if (adv) begin
              deliver      = 1'b1;
              deliver_word = imem.imem_rdata;
              state_d      = S_REQ;
            end else begin
              hold_d  = imem.imem_rdata;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (adv) begin
            deliver = 1'b1;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
      if (deliver) pc_d = pc_q + PC_STEP;
    end
  end

  always_comb begin
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    if (if_id_flush | redirect_valid) begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (deliver) begin
      id_pc_d    = fetch_pc_q;
      id_pc4_d   = fetch_pc_q + PC_STEP;
      id_instr_d = deliver_word;
      id_valid_d = 1'b1;
    end else if (if_id_write) begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      kill_q       <= 1'b0;
      hold_q       <= '0;
      misaligned_q <= 1'b0;
      id_pc_q      <= RESET_PC;
      id_pc4_q     <= RESET_PC + PC_STEP;
      id_instr_q   <= NOP_INSTR;
      id_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      kill_q       <= kill_d;
      hold_q       <= hold_d;
      misaligned_q <= misaligned_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      id_instr_q   <= id_instr_d;
      id_valid_q   <= id_valid_d;
    end
  end

  assign if_id_pc         = id_pc_q;
  assign if_id_pc4        = id_pc4_q;
  assign if_id_instr      = id_instr_q;
  assign if_id_valid      = id_valid_q;
  assign fetch_misaligned = misaligned_q;

endmodule
